// File: rtl/hive_rbus_arb.sv
// hive_rbus_arb: shares the register-set bus between REQ_N requesters.
// Port 0 is the processor core. It has absolute priority and is never stalled.
// Ports 1..REQ_N-1 are host/debug agents and are served round-robin in cycles
// where the core is idle. Strobes, address and write data are registered once
// before they reach the rbus. Each read is tagged so that the returned data is
// flagged to the port that issued it.
//
// Handshake: port k requests while req_rd_i[k] | req_wr_i[k] is high, and it
// holds rd/wr/addr/data stable until req_ack_o[k] is seen in the same cycle.
// The ack is combinational and marks the accepting cycle. In the next cycle the
// port may present a new request or drop. Read data returns RD_LAT+2 cycles
// after the ack, flagged by the one-hot req_rd_vld_o. Returns are in order.
//
// ALU_W and RBUS_ADDR_W default to the hive_params values (32 / 8).
module hive_rbus_arb #(
    parameter int REQ_N       = 3,
    parameter int RD_LAT      = 1,
    parameter int ALU_W       = 32,
    parameter int RBUS_ADDR_W = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [REQ_N-1:0]             req_rd_i,
    input  logic [REQ_N-1:0]             req_wr_i,
    input  logic [REQ_N*RBUS_ADDR_W-1:0] req_addr_i,
    input  logic [REQ_N*ALU_W-1:0]       req_wr_data_i,
    output logic [REQ_N-1:0]             req_ack_o,
    output logic [REQ_N-1:0]             req_rd_vld_o,
    output logic [ALU_W-1:0]             req_rd_data_o,
    output logic                         rbus_rd_o,
    output logic                         rbus_wr_o,
    output logic [RBUS_ADDR_W-1:0]       rbus_addr_o,
    output logic [ALU_W-1:0]             rbus_wr_data_o,
    input  logic [ALU_W-1:0]             rbus_rd_data_i
);

    localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

    logic [REQ_N-1:0]       req;
    logic [REQ_N-1:0]       gnt;
    logic                   gnt_vld;
    logic [PTR_W-1:0]       ptr;
    logic                   sel_rd;
    logic                   sel_wr;
    logic [RBUS_ADDR_W-1:0] sel_addr;
    logic [ALU_W-1:0]       sel_data;
    logic [REQ_N-1:0]       tag_pipe [RD_LAT+1];

    assign req       = req_rd_i | req_wr_i;
    assign req_ack_o = gnt;

    // Grant: core first; otherwise first agent above ptr, then wrap back to port 1.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        if (!rst_i) begin
            if (req[0]) begin
                gnt[0]  = 1'b1;
                gnt_vld = 1'b1;
            end else begin
                for (int k = 1; k < REQ_N; k++) begin
                    if (!gnt_vld && req[k] && (k > int'(ptr))) begin
                        gnt[k]  = 1'b1;
                        gnt_vld = 1'b1;
                    end
                end
                for (int k = 1; k < REQ_N; k++) begin
                    if (!gnt_vld && req[k] && (k <= int'(ptr))) begin
                        gnt[k]  = 1'b1;
                        gnt_vld = 1'b1;
                    end
                end
            end
        end
    end

    // Select the strobes, address and write data of the granted port.
    always_comb begin
        sel_rd   = 1'b0;
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < REQ_N; k++) begin
            if (gnt[k]) begin
                sel_rd   = req_rd_i[k];
                sel_wr   = req_wr_i[k];
                sel_addr = req_addr_i[k*RBUS_ADDR_W +: RBUS_ADDR_W];
                sel_data = req_wr_data_i[k*ALU_W +: ALU_W];
            end
        end
    end

    generate
        if (REQ_N > 1) begin : g_rr
            // Round-robin pointer: follows agent grants only, core grants leave it alone.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    ptr <= PTR_W'(REQ_N - 1);
                end else if (gnt_vld && !gnt[0]) begin
                    for (int k = 1; k < REQ_N; k++) begin
                        if (gnt[k]) ptr <= PTR_W'(k);
                    end
                end
            end
        end else begin : g_no_rr
            assign ptr = '0;
        end
    endgenerate

    // Bus issue register: strobes last one cycle per grant, addr/data hold when idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rbus_rd_o      <= 1'b0;
            rbus_wr_o      <= 1'b0;
            rbus_addr_o    <= '0;
            rbus_wr_data_o <= '0;
        end else begin
            rbus_rd_o <= sel_rd;
            rbus_wr_o <= sel_wr;
            if (gnt_vld) begin
                rbus_addr_o    <= sel_addr;
                rbus_wr_data_o <= sel_data;
            end
        end
    end

    // Read tag pipe: stage 0 lines up with rbus_rd_o, stage RD_LAT with rbus_rd_data_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i <= RD_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= gnt & {REQ_N{sel_rd}};
            for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Return register: capture tagged read data, hold it when nothing is valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_rd_vld_o  <= '0;
            req_rd_data_o <= '0;
        end else begin
            req_rd_vld_o <= tag_pipe[RD_LAT];
            if (|tag_pipe[RD_LAT]) req_rd_data_o <= rbus_rd_data_i;
        end
    end

endmodule

// File: tb/tb_hive_rbus_arb.sv
// tb_hive_rbus_arb: directed stimulus with hand-computed expectations. The
// driver pushes expected acks, bus cycles and read returns (each stamped with
// the cycle it must appear in) into queues. A monitor on the falling edge pops
// and compares whenever the DUT shows an ack, a bus strobe or a read-valid.
module tb_hive_rbus_arb;

    localparam int REQ_N  = 3;
    localparam int RD_LAT = 1;
    localparam int AW     = 8;
    localparam int DW     = 32;

    localparam int ACK_W = 32 + REQ_N;
    localparam int BUS_W = 32 + 2 + AW + DW;
    localparam int RD_W  = 32 + REQ_N + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // ---------------- DUT ----------------
    logic [REQ_N-1:0]    req_rd_i;
    logic [REQ_N-1:0]    req_wr_i;
    logic [REQ_N*AW-1:0] req_addr_i;
    logic [REQ_N*DW-1:0] req_wr_data_i;
    logic [REQ_N-1:0]    req_ack_o;
    logic [REQ_N-1:0]    req_rd_vld_o;
    logic [DW-1:0]       req_rd_data_o;
    logic                rbus_rd_o;
    logic                rbus_wr_o;
    logic [AW-1:0]       rbus_addr_o;
    logic [DW-1:0]       rbus_wr_data_o;
    logic [DW-1:0]       rbus_rd_data_i;

    hive_rbus_arb #(
        .REQ_N(REQ_N), .RD_LAT(RD_LAT), .ALU_W(DW), .RBUS_ADDR_W(AW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_rd_i      (req_rd_i),
        .req_wr_i      (req_wr_i),
        .req_addr_i    (req_addr_i),
        .req_wr_data_i (req_wr_data_i),
        .req_ack_o     (req_ack_o),
        .req_rd_vld_o  (req_rd_vld_o),
        .req_rd_data_o (req_rd_data_o),
        .rbus_rd_o     (rbus_rd_o),
        .rbus_wr_o     (rbus_wr_o),
        .rbus_addr_o   (rbus_addr_o),
        .rbus_wr_data_o(rbus_wr_data_o),
        .rbus_rd_data_i(rbus_rd_data_i)
    );

    // rbus slave: returns 0x100 + addr, RD_LAT cycles after the read strobe
    logic [DW-1:0] slv_pipe [RD_LAT];
    always @(posedge clk) begin
        slv_pipe[0] <= rbus_rd_o ? (DW'(32'h100) + {{(DW-AW){1'b0}}, rbus_addr_o}) : '0;
        for (int i = 1; i < RD_LAT; i++) slv_pipe[i] <= slv_pipe[i-1];
    end
    assign rbus_rd_data_i = slv_pipe[RD_LAT-1];

    // ---------------- scoreboard ----------------
    logic [ACK_W-1:0] exp_ack_q[$];
    logic [BUS_W-1:0] exp_bus_q[$];
    logic [RD_W-1:0]  exp_rd_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [127:0] act);
        checks++;
        errors++;
        $display("FAIL %s unexpected actual=%h required=none", name, act);
    endtask

    // monitor: compares whenever the DUT presents an ack, a bus strobe or a read return
    always @(negedge clk) begin
        if (|req_ack_o) begin
            if (exp_ack_q.size() == 0) unexpected("ack", 128'({cyc, req_ack_o}));
            else chk("ack", 128'({cyc, req_ack_o}), 128'(exp_ack_q.pop_front()));
        end
        if (rbus_rd_o || rbus_wr_o) begin
            if (exp_bus_q.size() == 0)
                unexpected("bus", 128'({cyc, rbus_rd_o, rbus_wr_o, rbus_addr_o, rbus_wr_data_o}));
            else
                chk("bus", 128'({cyc, rbus_rd_o, rbus_wr_o, rbus_addr_o, rbus_wr_data_o}),
                    128'(exp_bus_q.pop_front()));
        end
        if (|req_rd_vld_o) begin
            if (exp_rd_q.size() == 0) unexpected("rd_vld", 128'({cyc, req_rd_vld_o, req_rd_data_o}));
            else chk("rd_vld", 128'({cyc, req_rd_vld_o, req_rd_data_o}), 128'(exp_rd_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int k, input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_rd_i[k]                = rd;
        req_wr_i[k]                = wr;
        req_addr_i[k*AW +: AW]     = a;
        req_wr_data_i[k*DW +: DW]  = d;
    endtask

    task automatic idle_all();
        req_rd_i      = '0;
        req_wr_i      = '0;
        req_addr_i    = '0;
        req_wr_data_i = '0;
    endtask

    // expectations for a grant to port k in the current cycle
    task automatic exp_grant(input int k, input logic rd, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_ack_q.push_back({cyc, REQ_N'(1 << k)});
        exp_bus_q.push_back({cyc + 32'd1, rd, wr, a, d});
        if (rd) exp_rd_q.push_back({cyc + 32'(2 + RD_LAT), REQ_N'(1 << k),
                                    DW'(32'h100) + {{(DW-AW){1'b0}}, a}});
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"},     128'(req_ack_o),      128'(0));
        chk({tag, "_rbus_rd"}, 128'(rbus_rd_o),      128'(0));
        chk({tag, "_rbus_wr"}, 128'(rbus_wr_o),      128'(0));
        chk({tag, "_addr"},    128'(rbus_addr_o),    128'(0));
        chk({tag, "_wdata"},   128'(rbus_wr_data_o), 128'(0));
        chk({tag, "_rd_vld"},  128'(req_rd_vld_o),   128'(0));
        chk({tag, "_rd_data"}, 128'(req_rd_data_o),  128'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        idle_all();
        rst = 1'b1;
        // core requests while reset is high: no ack allowed
        set_port(0, 1'b1, 1'b0, 8'h12, 32'h0);
        tick();
        tick();
        check_all_zero("reset");
        idle_all();
        rst = 1'b0;

        // agents 1 and 2 write continuously: 1,2,1,2 starting with 1 after reset
        set_port(1, 1'b0, 1'b1, 8'h31, 32'h1111_1111);
        set_port(2, 1'b0, 1'b1, 8'h32, 32'h2222_2222);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_grant(1, 1'b0, 1'b1, 8'h31, 32'h1111_1111);
            else            exp_grant(2, 1'b0, 1'b1, 8'h32, 32'h2222_2222);
            tick();
        end
        idle_all();
        tick();

        // core and agent 1 together, core drops next cycle
        set_port(0, 1'b1, 1'b0, 8'h20, 32'h0000_0000);
        set_port(1, 1'b0, 1'b1, 8'h21, 32'hA5A5_A5A5);
        exp_grant(0, 1'b1, 1'b0, 8'h20, 32'h0000_0000);
        tick();
        set_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
        exp_grant(1, 1'b0, 1'b1, 8'h21, 32'hA5A5_A5A5);
        tick();
        idle_all();
        tick();

        // agent 2 single write
        set_port(2, 1'b0, 1'b1, 8'h05, 32'hDEAD_BEEF);
        exp_grant(2, 1'b0, 1'b1, 8'h05, 32'hDEAD_BEEF);
        tick();
        idle_all();
        tick();

        // back-to-back reads: agent 1 then agent 2
        set_port(1, 1'b1, 1'b0, 8'h01, 32'h0);
        exp_grant(1, 1'b1, 1'b0, 8'h01, 32'h0);
        tick();
        set_port(1, 1'b0, 1'b0, 8'h00, 32'h0);
        set_port(2, 1'b1, 1'b0, 8'h02, 32'h0);
        exp_grant(2, 1'b1, 1'b0, 8'h02, 32'h0);
        tick();
        idle_all();
        tick();

        // core reads 0x12 every cycle: fully pipelined returns of 0x112
        set_port(0, 1'b1, 1'b0, 8'h12, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_grant(0, 1'b1, 1'b0, 8'h12, 32'h0);
            tick();
        end
        idle_all();
        for (int i = 0; i < 5; i++) tick();

        // reset the cycle after an agent-1 read ack: read must vanish
        set_port(1, 1'b1, 1'b0, 8'h07, 32'h0);
        exp_ack_q.push_back({cyc, REQ_N'(1 << 1)});
        tick();
        idle_all();
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        tick();
        tick();
        rst = 1'b0;
        // both agents request; ptr was reset so port 1 goes first
        set_port(1, 1'b0, 1'b1, 8'h41, 32'h4141_4141);
        set_port(2, 1'b0, 1'b1, 8'h42, 32'h4242_4242);
        exp_grant(1, 1'b0, 1'b1, 8'h41, 32'h4141_4141);
        tick();
        set_port(1, 1'b0, 1'b0, 8'h00, 32'h0);
        exp_grant(2, 1'b0, 1'b1, 8'h42, 32'h4242_4242);
        tick();
        idle_all();
        for (int i = 0; i < 8; i++) tick();

        // ---------------- final report ----------------
        chk("ack_q_left", 128'(exp_ack_q.size()), 128'(0));
        chk("bus_q_left", 128'(exp_bus_q.size()), 128'(0));
        chk("rd_q_left",  128'(exp_rd_q.size()),  128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
